// File: rtl/seg7_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : seg7_sequencer
// Purpose  : Plays back a small buffer of seg7hex codes, each held for dwell+1
//            cycles and followed by GAP_CYCLES blank cycles.
// Option   : define SEG7_SEQ_ENDDOT_EN to show a dot marker at each sequence end.
// Revision : 1.0 - initial release
// ============================================================================
module seg7_sequencer #(
    parameter int DEPTH      = 8,
    parameter int DWELL_W    = 8,
    parameter int GAP_CYCLES = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  logic [3:0]                 wr_code,
    input  logic                       clear,
    input  logic                       start,
    input  logic                       loop,
    input  logic [DWELL_W-1:0]         dwell,
    output logic [3:0]                 hex,
    output logic                       busy,
    output logic                       full,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       done
);

    localparam int                 c_CNT_W    = $clog2(DEPTH + 1);
    localparam int                 c_IDX_W    = $clog2(DEPTH);
    localparam int                 c_GAP_W    = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam bit                 c_HAS_GAP  = (GAP_CYCLES > 0);
    localparam logic [c_GAP_W-1:0] c_GAP_LOAD = (GAP_CYCLES > 0) ? c_GAP_W'(GAP_CYCLES - 1) : '0;
    localparam logic [3:0]         c_BLANK    = 4'd15;
`ifdef SEG7_SEQ_ENDDOT_EN
    localparam logic [3:0]         c_DOT      = 4'd10;
`endif

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_SHOW = 3'd1,
        S_GAP  = 3'd2,
        S_DOT  = 3'd3,
        S_DGAP = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [c_IDX_W-1:0]   idx_q,   idx_d;
    logic [c_CNT_W-1:0]   count_q, count_d;
    logic [DWELL_W-1:0]   dcnt_q,  dcnt_d;
    logic [c_GAP_W-1:0]   gcnt_q,  gcnt_d;
    logic [3:0]           hex_q,   hex_d;
    logic                 done_q,  done_d;
    logic [3:0]           mem_q [DEPTH];

    logic                 w_full;
    logic                 w_buf_we;
    logic                 w_step;
    logic                 w_end;
    logic [3:0]           w_first;
    logic [c_IDX_W-1:0]   w_idx_nx;
    logic [c_CNT_W-1:0]   w_idx_inc;

    assign w_full    = (count_q == c_CNT_W'(DEPTH));
    assign w_idx_nx  = idx_q + c_IDX_W'(1);
    assign w_idx_inc = c_CNT_W'(idx_q) + c_CNT_W'(1);
    // A write and start in the same idle cycle into an empty buffer plays the new code.
    assign w_first   = (count_q == '0) ? wr_code : mem_q[0];

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        count_d  = count_q;
        dcnt_d   = dcnt_q;
        gcnt_d   = gcnt_q;
        hex_d    = hex_q;
        done_d   = 1'b0;
        w_buf_we = 1'b0;
        w_step   = 1'b0;
        w_end    = 1'b0;

        if (clear) begin
            state_d = S_IDLE;
            idx_d   = '0;
            count_d = '0;
            dcnt_d  = '0;
            gcnt_d  = '0;
            hex_d   = c_BLANK;
        end else begin
            case (state_q)
                S_IDLE: begin
                    hex_d = c_BLANK;
                    if (wr_en && !w_full) begin
                        w_buf_we = 1'b1;
                        count_d  = count_q + c_CNT_W'(1);
                    end
                    if (start && (count_q != '0 || w_buf_we)) begin
                        state_d = S_SHOW;
                        idx_d   = '0;
                        dcnt_d  = dwell;
                        hex_d   = w_first;
                    end
                end
                S_SHOW: begin
                    if (dcnt_q != '0) begin
                        dcnt_d = dcnt_q - DWELL_W'(1);
                    end else if (c_HAS_GAP) begin
                        state_d = S_GAP;
                        gcnt_d  = c_GAP_LOAD;
                        hex_d   = c_BLANK;
                    end else begin
                        w_step = 1'b1;
                    end
                end
                S_GAP: begin
                    if (gcnt_q != '0) begin
                        gcnt_d = gcnt_q - c_GAP_W'(1);
                    end else begin
                        w_step = 1'b1;
                    end
                end
                S_DOT: begin
                    if (dcnt_q != '0) begin
                        dcnt_d = dcnt_q - DWELL_W'(1);
                    end else if (c_HAS_GAP) begin
                        state_d = S_DGAP;
                        gcnt_d  = c_GAP_LOAD;
                        hex_d   = c_BLANK;
                    end else begin
                        w_end = 1'b1;
                    end
                end
                S_DGAP: begin
                    if (gcnt_q != '0) begin
                        gcnt_d = gcnt_q - c_GAP_W'(1);
                    end else begin
                        w_end = 1'b1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    hex_d   = c_BLANK;
                end
            endcase

            if (w_step) begin
                if (w_idx_inc < count_q) begin
                    state_d = S_SHOW;
                    idx_d   = w_idx_nx;
                    dcnt_d  = dwell;
                    hex_d   = mem_q[w_idx_nx];
                end else begin
`ifdef SEG7_SEQ_ENDDOT_EN
                    state_d = S_DOT;
                    dcnt_d  = dwell;
                    hex_d   = c_DOT;
`else
                    w_end   = 1'b1;
`endif
                end
            end

            // Sequence end: loop is sampled only here.
            if (w_end) begin
                idx_d = '0;
                if (loop) begin
                    state_d = S_SHOW;
                    dcnt_d  = dwell;
                    hex_d   = mem_q[0];
                end else begin
                    state_d = S_IDLE;
                    hex_d   = c_BLANK;
                    done_d  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            count_q <= '0;
            dcnt_q  <= '0;
            gcnt_q  <= '0;
            hex_q   <= c_BLANK;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            count_q <= count_d;
            dcnt_q  <= dcnt_d;
            gcnt_q  <= gcnt_d;
            hex_q   <= hex_d;
            done_q  <= done_d;
        end
    end

    // Buffer storage needs no reset; contents beyond count are never shown.
    always_ff @(posedge clk) begin
        if (w_buf_we) begin
            mem_q[count_q[c_IDX_W-1:0]] <= wr_code;
        end
    end

    assign hex   = hex_q;
    assign busy  = (state_q != S_IDLE);
    assign full  = w_full;
    assign count = count_q;
    assign done  = done_q;

endmodule
`default_nettype wire

// File: tb/tb_seg7_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg7_sequencer
// Purpose  : Directed self-checking bench with an expected-output scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg7_sequencer;

    localparam int TB_DEPTH = 8;
    localparam int TB_DW    = 8;
    localparam int TB_GAP   = 2;
    localparam int TB_CW    = $clog2(TB_DEPTH + 1);

    logic              clk;
    logic              rst_n;
    logic              wr_en;
    logic [3:0]        wr_code;
    logic              clear;
    logic              start;
    logic              loop;
    logic [TB_DW-1:0]  dwell;
    logic [3:0]        hex;
    logic              busy;
    logic              full;
    logic [TB_CW-1:0]  count;
    logic              done;

    typedef struct packed {
        logic [3:0] hex;
        logic       busy;
        logic       done;
    } exp_t;

    exp_t       sb[$];
    logic [3:0] seq[$];
    int         checks   = 0;
    int         failures = 0;

    seg7_sequencer #(
        .DEPTH      (TB_DEPTH),
        .DWELL_W    (TB_DW),
        .GAP_CYCLES (TB_GAP)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_code (wr_code),
        .clear   (clear),
        .start   (start),
        .loop    (loop),
        .dwell   (dwell),
        .hex     (hex),
        .busy    (busy),
        .full    (full),
        .count   (count),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [3:0] code);
        wr_en   = 1'b1;
        wr_code = code;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    task automatic push(input logic [3:0] h, input logic b, input logic d);
        exp_t e;
        e.hex  = h;
        e.busy = b;
        e.done = d;
        sb.push_back(e);
    endtask

    // Expected display stream for a playback of seq, built from the behaviour.
    task automatic push_passes(input int dw, input int passes);
        for (int p = 0; p < passes; p++) begin
            foreach (seq[k]) begin
                repeat (dw + 1) push(seq[k], 1'b1, 1'b0);
                repeat (TB_GAP) push(4'd15, 1'b1, 1'b0);
            end
`ifdef SEG7_SEQ_ENDDOT_EN
            repeat (dw + 1) push(4'd10, 1'b1, 1'b0);
            repeat (TB_GAP) push(4'd15, 1'b1, 1'b0);
`endif
        end
        push(4'd15, 1'b0, 1'b1);
        push(4'd15, 1'b0, 1'b0);
    endtask

    // Pops one expectation per cycle; start must already be driven high.
    task automatic play(input string tag, input int drop_at, input bit hold_wr, input int exp_count);
        exp_t e;
        int   i;
        i = 0;
        while (sb.size() > 0) begin
            @(negedge clk);
            start = 1'b0;
            if (i == drop_at) loop = 1'b0;
            e = sb.pop_front();
            check($sformatf("%s_hex[%0d]", tag, i),  32'(hex),   32'(e.hex));
            check($sformatf("%s_busy[%0d]", tag, i), 32'(busy),  32'(e.busy));
            check($sformatf("%s_done[%0d]", tag, i), 32'(done),  32'(e.done));
            check($sformatf("%s_cnt[%0d]", tag, i),  32'(count), 32'(exp_count));
            wr_en   = hold_wr && e.busy;
            wr_code = 4'd9;
            i++;
        end
        wr_en = 1'b0;
    endtask

    initial begin
        int pl;
        rst_n   = 1'b0;
        wr_en   = 1'b0;
        wr_code = 4'd0;
        clear   = 1'b0;
        start   = 1'b0;
        loop    = 1'b0;
        dwell   = '0;

        repeat (2) @(negedge clk);
        check("rst_hex",   32'(hex),   32'd15);
        check("rst_busy",  32'(busy),  32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_done",  32'(done),  32'd0);
        check("rst_full",  32'(full),  32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_hex",  32'(hex),   32'd15);
        check("idle_busy", 32'(busy),  32'd0);

        // 3,3,7 with dwell 1; writes attempted during playback must be ignored.
        dwell = 8'd1;
        wr(4'd3); wr(4'd3); wr(4'd7);
        check("a_count", 32'(count), 32'd3);
        seq = '{4'd3, 4'd3, 4'd7};
        push_passes(1, 1);
        start = 1'b1;
        play("a", -1, 1'b1, 3);

        // Looping 1,2 with dwell 0; loop dropped during the fourth pass.
        do_clear();
        wr(4'd1); wr(4'd2);
        dwell = 8'd0;
        loop  = 1'b1;
        seq   = '{4'd1, 4'd2};
        pl    = 2 * (1 + TB_GAP);
`ifdef SEG7_SEQ_ENDDOT_EN
        pl    = pl + 1 + TB_GAP;
`endif
        push_passes(0, 4);
        start = 1'b1;
        play("lp", 3 * pl + 1, 1'b0, 2);

        // Fill to capacity, overflow write, then clear mid-SHOW.
        do_clear();
        dwell = 8'd1;
        for (int k = 0; k < 7; k++) wr(4'(k));
        check("f_full7", 32'(full), 32'd0);
        wr(4'd7);
        check("f_full8",  32'(full),  32'd1);
        check("f_count8", 32'(count), 32'd8);
        wr(4'd8);
        check("f_count9", 32'(count), 32'd8);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("f_busy", 32'(busy), 32'd1);
        check("f_hex0", 32'(hex),  32'd0);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check("clr_busy",  32'(busy),  32'd0);
        check("clr_hex",   32'(hex),   32'd15);
        check("clr_count", 32'(count), 32'd0);
        check("clr_full",  32'(full),  32'd0);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("clr_done[%0d]", k), 32'(done), 32'd0);
            @(negedge clk);
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("empty_start_busy", 32'(busy), 32'd0);
        check("empty_start_hex",  32'(hex),  32'd15);

        // Write and start in the same idle cycle.
        dwell   = 8'd0;
        seq     = '{4'd4};
        push_passes(0, 1);
        wr_en   = 1'b1;
        wr_code = 4'd4;
        start   = 1'b1;
        play("ws", -1, 1'b0, 1);

        // Maximum dwell with a code the decoder blanks.
        do_clear();
        wr(4'd12);
        dwell = 8'hFF;
        seq   = '{4'd12};
        push_passes(255, 1);
        start = 1'b1;
        play("mx", -1, 1'b0, 1);

        // Asynchronous reset while showing a code.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("ar_busy_pre", 32'(busy), 32'd1);
        check("ar_hex_pre",  32'(hex),  32'd12);
        #2 rst_n = 1'b0;
        #1;
        check("ar_hex",   32'(hex),   32'd15);
        check("ar_busy",  32'(busy),  32'd0);
        check("ar_count", 32'(count), 32'd0);
        check("ar_done",  32'(done),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("ar_idle_busy", 32'(busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seg7_sequencer.md
Name: seg7_sequencer

Overview:
- Playback controller for a single 7-segment digit. Stores a short sequence of 4-bit digit codes and steps through them with a programmable dwell time.
- Drives the 4-bit code input of the team's seg7hex decoder:
  - codes 0-9 are digits
  - code 10 is the dot
  - any other code is blank
- Inserts a blank gap between codes so that repeated digits such as "33" stay distinguishable.
- Sits between the design's input pins and the decoder; it is the only driver of the decoder's code input.

Parameters:
- DEPTH, 8, number of code entries in the sequence buffer (power of 2, at least 2)
- DWELL_W, 8, width of the dwell input
- GAP_CYCLES, 2, blank cycles inserted after each code; 0 means no gap

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- wr_en  in  1  append wr_code to the buffer
- wr_code  in  4  code to append
- clear  in  1  empty the buffer and abort playback
- start  in  1  begin playback (level sampled)
- loop  in  1  repeat the sequence continuously; sampled at each sequence end
- dwell  in  DWELL_W  each code is shown for dwell+1 cycles; sampled on entry to SHOW
- hex  out  4  code to the decoder (registered)
- busy  out  1  playback in progress
- full  out  1  count == DEPTH
- count  out  clog2(DEPTH+1)  number of stored codes
- done  out  1  one-cycle pulse at the end of non-looping playback

Behaviour:
- Single clock domain. Reset is asynchronous and active-low.
- Reset values: hex = 4'd15 (blank), busy = 0, full = 0, count = 0, done = 0. State IDLE, idx = 0, dwell counter = 0.
- States:
  - IDLE: hex = 15, busy = 0.
  - SHOW: hex = buf[idx], held for dwell+1 cycles.
  - GAP: hex = 15, held for GAP_CYCLES cycles. Skipped entirely when GAP_CYCLES = 0.
  - busy = 1 in SHOW and GAP.
- Write rules:
  - wr_en in IDLE with count < DEPTH: buf[count] <= wr_code, count++.
  - wr_en is ignored when full or busy. There is no error flag.
- Start rules:
  - start in IDLE with count > 0 enters SHOW with idx = 0.
  - hex = buf[0] from the same clock edge, i.e. zero added latency after start is sampled.
  - start in IDLE with count == 0 is ignored.
  - start while busy is ignored.
- Transitions:
  - SHOW to GAP (or to the next step when GAP_CYCLES = 0) after dwell+1 cycles.
  - At the end of each code, if idx < count-1: idx++ and enter SHOW.
  - Otherwise (sequence end):
    - loop = 1: idx = 0, enter SHOW.
    - loop = 0: enter IDLE, hex = 15, done = 1 for exactly one cycle.
- Simultaneous events:
  - wr_en and start in the same IDLE cycle: the write commits and playback includes the new code.
  - clear beats wr_en and start in the same cycle.
- clear:
  - Takes effect at the next edge from any state: count = 0, idx = 0, IDLE, hex = 15.
  - Buffer contents are don't-care afterwards.
  - A clear during playback produces no done pulse.
- Reset mid-playback returns all outputs to their reset values immediately (asynchronous).
- Arithmetic:
  - The dwell counter is DWELL_W bits. dwell = all ones gives 2^DWELL_W cycles with no overflow.
  - idx wraps only through the sequence-end rule, never by arithmetic overflow.
- Codes 11-15 are stored and replayed verbatim; the decoder displays them as blank.

Optional Feature:
- Macro: SEG7_SEQ_ENDDOT_EN.
- Defined: at sequence end, before the done/loop decision, the block shows hex = 4'd10 (dot) for dwell+1 cycles, then GAP_CYCLES blank cycles, then applies the end rule. This marks the wrap point during looped playback.
- Undefined: the end rule applies directly after the last code's gap, exactly as in Behaviour.

Test Plan:
- Reset then idle -> hex = 15, busy = 0, count = 0, done = 0. Assert rst_n low mid-SHOW -> hex = 15 and busy = 0 without waiting for a clk edge.
- Write codes 3, 3, 7 with dwell = 1, GAP_CYCLES = 2, loop = 0, then start -> hex follows 3,3,15,15,3,3,15,15,7,7,15,15. Then IDLE, done pulses for exactly 1 cycle, count stays 3.
- Write 9 codes with DEPTH = 8 -> full = 1 after the 8th write, 9th write ignored, count = 8. wr_en during playback leaves count unchanged.
- Load 1, 2 with loop = 1 and dwell = 0, start, run 3 full passes, then drop loop -> output repeats 1,15,15,2,15,15 and done pulses only after the final pass.
- Assert clear mid-SHOW -> next cycle state is IDLE, hex = 15, count = 0, no done pulse. start with count = 0 -> stays idle.
- With SEG7_SEQ_ENDDOT_EN defined, load code 5, dwell = 2, GAP_CYCLES = 0 -> output is 5,5,5,10,10,10 followed by the done pulse.
